// File: rtl/dlf_gear_ctrl.sv
// dlf_gear_ctrl: bandwidth gear-shift sequencer for the digital loop filter.
// Holds the filter off while settling, acquires wide, then tracks once phase error is small.
module dlf_gear_ctrl #(
    parameter int PHE_W  = 21,
    parameter int COEF_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [PHE_W-1:0]  phe_in,
    input  logic              phe_vld,
    input  logic [COEF_W-1:0] acq_a2,
    input  logic [COEF_W-1:0] acq_a3,
    input  logic [COEF_W-1:0] acq_b1,
    input  logic [COEF_W-1:0] acq_b2,
    input  logic [COEF_W-1:0] trk_a2,
    input  logic [COEF_W-1:0] trk_a3,
    input  logic [COEF_W-1:0] trk_b1,
    input  logic [COEF_W-1:0] trk_b2,
    input  logic [PHE_W-2:0]  lock_thr,
    input  logic [7:0]        lock_cnt,
    input  logic [CNT_W-1:0]  settle_cyc,
    input  logic [CNT_W-1:0]  acq_timeout,
    output logic              dlf_en,
    output logic [COEF_W-1:0] dlf_a2,
    output logic [COEF_W-1:0] dlf_a3,
    output logic [COEF_W-1:0] dlf_b1,
    output logic [COEF_W-1:0] dlf_b2,
    output logic              coef_upd,
    output logic              locked,
    output logic              busy,
    output logic              timeout_err,
    output logic [2:0]        state_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ACQ    = 3'd2,
        S_SWITCH = 3'd3,
        S_TRACK  = 3'd4
    } state_t;

    typedef logic [3:0][COEF_W-1:0] coef_set_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] settle_q, settle_d, tmo_q, tmo_d;
    logic [7:0]       run_q, run_d, lck_q, lck_d;
    logic [PHE_W-2:0] thr_q, thr_d;
    coef_set_t        acq_q, acq_d, trk_q, trk_d, coef_q, coef_d;
    logic             en_q, en_d, upd_q, upd_d;
    logic             locked_q, locked_d, busy_q, busy_d;
    logic             terr_q, terr_d;

    logic [PHE_W-1:0] neg;
    logic [PHE_W-2:0] mag;
    logic [7:0]       lim, run_inc;
    logic [CNT_W-1:0] settle_dec, tmo_inc;
    logic             in_thr, out_wide;

    // |phe| saturates the most-negative code to the largest magnitude
    always_comb begin
        neg = ~phe_in + 1'b1;
        if (!phe_in[PHE_W-1]) begin
            mag = phe_in[PHE_W-2:0];
        end else if (phe_in[PHE_W-2:0] == '0) begin
            mag = '1;
        end else begin
            mag = neg[PHE_W-2:0];
        end
    end

    assign in_thr     = (mag <= thr_q);
    assign out_wide   = ({1'b0, mag} > {thr_q, 1'b0});
    assign lim        = (lck_q == 8'd0) ? 8'd1 : lck_q;
    assign run_inc    = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    assign settle_dec = (settle_q == '0) ? '0 : settle_q - CNT_W'(1);
    assign tmo_inc    = tmo_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        run_d    = run_q;
        lck_d    = lck_q;
        thr_d    = thr_q;
        acq_d    = acq_q;
        trk_d    = trk_q;
        coef_d   = coef_q;
        en_d     = en_q;
        upd_d    = 1'b0;
        locked_d = locked_q;
        terr_d   = terr_q;
        unique case (state_q)
            S_IDLE: begin
                en_d = 1'b0;
                if (start && !abort) begin
                    acq_d    = {acq_b2, acq_b1, acq_a3, acq_a2};
                    trk_d    = {trk_b2, trk_b1, trk_a3, trk_a2};
                    thr_d    = lock_thr;
                    lck_d    = lock_cnt;
                    settle_d = settle_cyc;
                    terr_d   = 1'b0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_dec;
                if (settle_dec == '0) begin
                    state_d = S_ACQ;
                    coef_d  = acq_q;
                    upd_d   = 1'b1;
                    en_d    = 1'b1;
                    run_d   = 8'd0;
                    tmo_d   = '0;
                end
            end
            S_ACQ: begin
                if (phe_vld) begin
                    run_d = in_thr ? run_inc : 8'd0;
                    tmo_d = tmo_inc;
                    if (run_d >= lim) begin
                        state_d = S_SWITCH;
                    end else if (acq_timeout != '0 && tmo_inc == acq_timeout) begin
                        state_d = S_IDLE;
                        terr_d  = 1'b1;
                        en_d    = 1'b0;
                    end
                end
            end
            S_SWITCH: begin
                if (phe_vld) begin
                    coef_d   = trk_q;
                    upd_d    = 1'b1;
                    locked_d = 1'b1;
                    run_d    = 8'd0;
                    state_d  = S_TRACK;
                end
            end
            S_TRACK: begin
                en_d = 1'b1;
                if (phe_vld) begin
                    run_d = out_wide ? run_inc : 8'd0;
                    if (run_d >= lim) begin
                        state_d  = S_ACQ;
                        coef_d   = acq_q;
                        upd_d    = 1'b1;
                        locked_d = 1'b0;
                        run_d    = 8'd0;
                        tmo_d    = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort keeps coefficients and the sticky error
        if (abort) begin
            state_d  = S_IDLE;
            en_d     = 1'b0;
            locked_d = 1'b0;
            upd_d    = 1'b0;
            coef_d   = coef_q;
            terr_d   = terr_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            run_q    <= '0;
            lck_q    <= '0;
            thr_q    <= '0;
            acq_q    <= '0;
            trk_q    <= '0;
            coef_q   <= '0;
            en_q     <= 1'b0;
            upd_q    <= 1'b0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            run_q    <= run_d;
            lck_q    <= lck_d;
            thr_q    <= thr_d;
            acq_q    <= acq_d;
            trk_q    <= trk_d;
            coef_q   <= coef_d;
            en_q     <= en_d;
            upd_q    <= upd_d;
            locked_q <= locked_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
        end
    end

    assign dlf_en      = en_q;
    assign dlf_a2      = coef_q[0];
    assign dlf_a3      = coef_q[1];
    assign dlf_b1      = coef_q[2];
    assign dlf_b2      = coef_q[3];
    assign coef_upd    = upd_q;
    assign locked      = locked_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dlf_gear_ctrl.sv
// tb_dlf_gear_ctrl: directed and randomized checks of the gear-shift sequencer
// against an integer-level behavioural model.
module tb_dlf_gear_ctrl;
    localparam int PHE_W  = 21;
    localparam int COEF_W = 16;
    localparam int CNT_W  = 16;
    localparam int MAGMAX = (1 << (PHE_W - 1)) - 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              phe_vld = 1'b0;
    logic [PHE_W-1:0]  phe_in = '0;
    logic [COEF_W-1:0] acq_a2 = '0, acq_a3 = '0, acq_b1 = '0, acq_b2 = '0;
    logic [COEF_W-1:0] trk_a2 = '0, trk_a3 = '0, trk_b1 = '0, trk_b2 = '0;
    logic [PHE_W-2:0]  lock_thr = '0;
    logic [7:0]        lock_cnt = '0;
    logic [CNT_W-1:0]  settle_cyc = '0;
    logic [CNT_W-1:0]  acq_timeout = '0;

    logic              dlf_en, coef_upd, locked, busy, timeout_err;
    logic [COEF_W-1:0] dlf_a2, dlf_a3, dlf_b1, dlf_b2;
    logic [2:0]        state_o;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_state, m_left, m_run, m_tmo, m_en, m_upd, m_lock, m_terr;
    int m_thr, m_lck;
    int m_coef[4];
    int sh_acq[4];
    int sh_trk[4];

    dlf_gear_ctrl #(.PHE_W(PHE_W), .COEF_W(COEF_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .phe_in(phe_in), .phe_vld(phe_vld),
        .acq_a2(acq_a2), .acq_a3(acq_a3), .acq_b1(acq_b1), .acq_b2(acq_b2),
        .trk_a2(trk_a2), .trk_a3(trk_a3), .trk_b1(trk_b1), .trk_b2(trk_b2),
        .lock_thr(lock_thr), .lock_cnt(lock_cnt),
        .settle_cyc(settle_cyc), .acq_timeout(acq_timeout),
        .dlf_en(dlf_en), .dlf_a2(dlf_a2), .dlf_a3(dlf_a3),
        .dlf_b1(dlf_b1), .dlf_b2(dlf_b2), .coef_upd(coef_upd),
        .locked(locked), .busy(busy), .timeout_err(timeout_err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic int mag_of(input logic [PHE_W-1:0] v);
        int p;
        p = $signed(v);
        if (p < 0) p = -p;
        if (p > MAGMAX) p = MAGMAX;
        return p;
    endfunction

    task automatic enter_acq();
        m_state = 2;
        m_coef  = sh_acq;
        m_upd   = 1;
        m_en    = 1;
        m_run   = 0;
        m_tmo   = 0;
    endtask

    task automatic model_step();
        int mag;
        int lim;
        m_upd = 0;
        if (!rstn) begin
            m_state = 0; m_left = 0; m_run = 0; m_tmo = 0;
            m_en = 0; m_lock = 0; m_terr = 0; m_thr = 0; m_lck = 0;
            foreach (m_coef[i]) begin
                m_coef[i] = 0; sh_acq[i] = 0; sh_trk[i] = 0;
            end
            return;
        end
        if (abort) begin
            m_state = 0; m_en = 0; m_lock = 0;
            return;
        end
        mag = mag_of(phe_in);
        lim = (m_lck == 0) ? 1 : m_lck;
        case (m_state)
            0: if (start) begin
                sh_acq = '{int'(acq_a2), int'(acq_a3), int'(acq_b1), int'(acq_b2)};
                sh_trk = '{int'(trk_a2), int'(trk_a3), int'(trk_b1), int'(trk_b2)};
                m_thr  = int'(lock_thr);
                m_lck  = int'(lock_cnt);
                m_left = (settle_cyc == 0) ? 1 : int'(settle_cyc);
                m_terr = 0;
                m_state = 1;
            end
            1: begin
                m_left--;
                if (m_left == 0) enter_acq();
            end
            2: if (phe_vld) begin
                m_run = (mag <= m_thr) ? ((m_run < 255) ? m_run + 1 : 255) : 0;
                m_tmo++;
                if (m_run >= lim) begin
                    m_state = 3;
                end else if (acq_timeout != 0 && m_tmo == int'(acq_timeout)) begin
                    m_state = 0; m_terr = 1; m_en = 0;
                end
            end
            3: if (phe_vld) begin
                m_coef = sh_trk; m_upd = 1; m_lock = 1; m_run = 0; m_state = 4;
            end
            4: if (phe_vld) begin
                m_run = (mag > 2 * m_thr) ? ((m_run < 255) ? m_run + 1 : 255) : 0;
                if (m_run >= lim) begin
                    enter_acq();
                    m_lock = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state_o), 32'(m_state));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("dlf_en", 32'(dlf_en), 32'(m_en));
        chk("coef_upd", 32'(coef_upd), 32'(m_upd));
        chk("locked", 32'(locked), 32'(m_lock));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("dlf_a2", 32'(dlf_a2), 32'(m_coef[0]));
        chk("dlf_a3", 32'(dlf_a3), 32'(m_coef[1]));
        chk("dlf_b1", 32'(dlf_b1), 32'(m_coef[2]));
        chk("dlf_b2", 32'(dlf_b2), 32'(m_coef[3]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic send(input int p);
        phe_in  = p[PHE_W-1:0];
        phe_vld = 1'b1;
        cyc();
        phe_vld = 1'b0;
        cyc();
    endtask

    initial begin
        int k;
        int p;
        acq_a2 = 16'h1111; acq_a3 = 16'h2222; acq_b1 = 16'h3333; acq_b2 = 16'h4444;
        trk_a2 = 16'h5555; trk_a3 = 16'h6666; trk_b1 = 16'h7777; trk_b2 = 16'h8888;
        lock_thr = 20'd100; lock_cnt = 8'd4; settle_cyc = 16'd3; acq_timeout = 16'd0;

        rstn = 1'b0;
        cyc(); cyc();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_en", 32'(dlf_en), 32'd0);
        chk("rst_a2", 32'(dlf_a2), 32'd0);
        rstn = 1'b1;

        // settle of 3 cycles, then acquisition coefficients
        start = 1'b1; cyc(); start = 1'b0;
        chk("t1_settle", 32'(state_o), 32'd1);
        cyc(); cyc();
        chk("t1_still_settle", 32'(state_o), 32'd1);
        cyc();
        chk("t1_acq", 32'(state_o), 32'd2);
        chk("t1_en", 32'(dlf_en), 32'd1);
        chk("t1_a2", 32'(dlf_a2), 32'h1111);
        chk("t1_upd", 32'(coef_upd), 32'd1);
        cyc();
        chk("t1_upd_pulse", 32'(coef_upd), 32'd0);

        // lock after the run of four in-threshold samples
        send(50); send(-80); send(120);
        acq_a2 = 16'hAAAA;
        send(30); send(40); send(-100);
        chk("t2_no_lock_yet", 32'(state_o), 32'd2);
        send(90);
        chk("t2_switch", 32'(state_o), 32'd3);
        chk("t2_not_locked", 32'(locked), 32'd0);
        chk("t2_acq_held", 32'(dlf_a2), 32'h1111);
        phe_in = 21'd10; phe_vld = 1'b1; cyc(); phe_vld = 1'b0;
        chk("t2_track", 32'(state_o), 32'd4);
        chk("t2_locked", 32'(locked), 32'd1);
        chk("t2_trk_a2", 32'(dlf_a2), 32'h5555);
        chk("t2_upd", 32'(coef_upd), 32'd1);
        cyc();

        // unlock; last bad sample is the saturating most-negative code
        send(250); send(250); send(-250);
        chk("t4_still_track", 32'(state_o), 32'd4);
        phe_in = 21'h100000; phe_vld = 1'b1; cyc(); phe_vld = 1'b0;
        chk("t4_back_acq", 32'(state_o), 32'd2);
        chk("t4_unlocked", 32'(locked), 32'd0);
        chk("t6_latched_a2", 32'(dlf_a2), 32'h1111);
        chk("t4_upd", 32'(coef_upd), 32'd1);
        cyc();

        abort = 1'b1; cyc(); abort = 1'b0;
        chk("t5_abort_acq", 32'(state_o), 32'd0);
        chk("t5_abort_en", 32'(dlf_en), 32'd0);
        chk("t5_coef_hold", 32'(dlf_a2), 32'h1111);

        // acquisition timeout after ten bad samples
        acq_timeout = 16'd10; settle_cyc = 16'd0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("t3_settle0_acq", 32'(state_o), 32'd2);
        chk("t3_new_a2", 32'(dlf_a2), 32'hAAAA);
        for (int i = 0; i < 9; i++) send(500);
        chk("t3_before_tmo", 32'(state_o), 32'd2);
        send(500);
        chk("t3_tmo_idle", 32'(state_o), 32'd0);
        chk("t3_tmo_en", 32'(dlf_en), 32'd0);
        chk("t3_tmo_err", 32'(timeout_err), 32'd1);
        start = 1'b1; abort = 1'b1; cyc(); abort = 1'b0; start = 1'b0;
        chk("t5_start_abort", 32'(state_o), 32'd0);
        chk("t5_err_kept", 32'(timeout_err), 32'd1);
        settle_cyc = 16'd5; acq_timeout = 16'd0;
        start = 1'b1; cyc(); start = 1'b0;
        chk("t3_err_clear", 32'(timeout_err), 32'd0);
        cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("t5_abort_settle", 32'(state_o), 32'd0);

        // abort from TRACK
        start = 1'b1; cyc(); start = 1'b0;
        repeat (5) cyc();
        for (int i = 0; i < 4; i++) send(0);
        send(0);
        chk("t5_in_track", 32'(state_o), 32'd4);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("t5_abort_track", 32'(state_o), 32'd0);
        chk("t5_abort_lock", 32'(locked), 32'd0);
        chk("t5_trk_hold", 32'(dlf_a2), 32'h5555);

        for (int i = 0; i < 4000; i++) begin
            rstn    = ($urandom_range(0, 999) != 0);
            abort   = ($urandom_range(0, 149) == 0);
            start   = ($urandom_range(0, 9) == 0);
            phe_vld = ($urandom_range(0, 1) == 1);
            k = $urandom_range(0, 9);
            if (k == 0) begin
                phe_in = 21'h100000;
            end else if (k == 1) begin
                phe_in = 21'h0FFFFF;
            end else begin
                p = $urandom_range(0, 2 * int'(lock_thr) + 60);
                if ($urandom_range(0, 1) == 1) p = -p;
                phe_in = p[PHE_W-1:0];
            end
            if ($urandom_range(0, 39) == 0) begin
                lock_thr    = 20'($urandom_range(0, 300));
                lock_cnt    = 8'($urandom_range(0, 5));
                settle_cyc  = 16'($urandom_range(0, 4));
                acq_timeout = 16'($urandom_range(0, 40));
                acq_a2 = 16'($urandom); acq_a3 = 16'($urandom);
                acq_b1 = 16'($urandom); acq_b2 = 16'($urandom);
                trk_a2 = 16'($urandom); trk_a3 = 16'($urandom);
                trk_b1 = 16'($urandom); trk_b2 = 16'($urandom);
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
